// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM and ALU decoder for the multicycle MIPS datapath.
// Moore-style outputs decoded from state, plus the branch-qualified PC
// enable and the ALU function decode. Also counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch;
  logic       irwrite_s, regwrite_s, memwrite_s;
  logic       funct_ok;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Flags R-type funct codes the ALU decoder understands.
  always_comb begin
    funct_ok = 1'b0;
    unique case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      StFetch: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        alusrcb = 2'b11;
        unique case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype: begin
            state_d    = StExec;
            // Unknown funct is flagged but the instruction still runs as add.
            illegal_op = !funct_ok;
          end
          OpBeq:   state_d = StBranch;
          OpAddi:  state_d = StAddiEx;
          OpJ:     state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite_s = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write enables are gated by reset so nothing is written while it is held.
  always_comb begin
    irwrite  = irwrite_s & rst_n;
    regwrite = regwrite_s & rst_n;
    memwrite = memwrite_s & rst_n;
    pcen     = (pcwrite | (branch & zero)) & rst_n;
  end

  // ALU function decode from aluop and funct.
  always_comb begin
    alucontrol = 3'b000;
    unique case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        unique case (funct)
          6'b100010: alucontrol = 3'b001;
          6'b100100: alucontrol = 3'b010;
          6'b100101: alucontrol = 3'b011;
          6'b101010: alucontrol = 3'b101;
          default:   alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl, built with a 4-bit counter so
// the wrap case is short. Inputs change and outputs are sampled 1ns after
// the rising edge (or just after a falling edge around reset release).
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, instr_done, illegal_op;
  logic [2:0] alucontrol;
  logic [3:0] instr_count;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_count = 4'd0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if ({irwrite, pcen, regwrite, memwrite} !== 4'b0000) begin fails++;
      $display("FAIL reset_enables got %b want 0000", {irwrite, pcen, regwrite, memwrite}); end
    tests++; if ({iord, alusrca, alusrcb, pcsrc} !== 6'b000100) begin fails++;
      $display("FAIL reset_fetch_sel got %b want 000100", {iord, alusrca, alusrcb, pcsrc}); end
    tests++; if (instr_count !== 4'd0) begin fails++;
      $display("FAIL reset_count got %0d want 0", instr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_count = 4'd0;
    tests++; if ({irwrite, pcen} !== 2'b11) begin fails++;
      $display("FAIL fetch_after_reset got %b want 11", {irwrite, pcen}); end
  endtask

  task automatic test_lw();
    op = 6'b100011;
    tests++; if ({irwrite, pcen, iord} !== 3'b110) begin fails++;
      $display("FAIL lw_c0 got %b want 110", {irwrite, pcen, iord}); end
    tick();  // DECODE
    tests++; if ({alusrcb, irwrite, illegal_op} !== 4'b1100) begin fails++;
      $display("FAIL lw_c1 got %b want 1100", {alusrcb, irwrite, illegal_op}); end
    tick();  // MEMADR
    tests++; if ({alusrca, alusrcb} !== 3'b110) begin fails++;
      $display("FAIL lw_c2 got %b want 110", {alusrca, alusrcb}); end
    tick();  // MEMRD
    tests++; if ({iord, regwrite, memwrite} !== 3'b100) begin fails++;
      $display("FAIL lw_c3 got %b want 100", {iord, regwrite, memwrite}); end
    tick();  // MEMWB
    tests++; if ({regwrite, memtoreg, regdst, instr_done} !== 4'b1101) begin fails++;
      $display("FAIL lw_c4 got %b want 1101", {regwrite, memtoreg, regdst, instr_done}); end
    tick();  // FETCH
    exp_count = exp_count + 4'd1;
    tests++; if ({irwrite, instr_count} !== {1'b1, exp_count}) begin fails++;
      $display("FAIL lw_done got %b/%0d want 1/%0d", irwrite, instr_count, exp_count); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ac [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    op = 6'b000000;
    zero = 1'b1;  // must not leak into pcen outside BRANCH
    for (int i = 0; i < 4; i++) begin
      funct = fn[i];
      tick();  // DECODE
      tests++; if (illegal_op !== 1'b0) begin fails++;
        $display("FAIL rtype_illegal[%0d] got %b want 0", i, illegal_op); end
      tick();  // EXEC
      tests++; if ({alucontrol, pcen, alusrca, alusrcb} !== {ac[i], 4'b0100}) begin fails++;
        $display("FAIL rtype_exec[%0d] got %b want %b", i,
                 {alucontrol, pcen, alusrca, alusrcb}, {ac[i], 4'b0100}); end
      tick();  // ALUWB
      tests++; if ({regdst, regwrite, memtoreg, instr_done} !== 4'b1101) begin fails++;
        $display("FAIL rtype_wb[%0d] got %b want 1101", i,
                 {regdst, regwrite, memtoreg, instr_done}); end
      tick();  // FETCH
      exp_count = exp_count + 4'd1;
      tests++; if ({irwrite, instr_count} !== {1'b1, exp_count}) begin fails++;
        $display("FAIL rtype_done[%0d] got %b/%0d want 1/%0d", i, irwrite, instr_count,
                 exp_count); end
    end
    zero = 1'b0;
  endtask

  task automatic test_beq();
    op = 6'b000100;
    zero = 1'b1;
    tick(); tick();  // BRANCH
    tests++; if ({pcen, pcsrc, alucontrol, instr_done} !== 7'b1010011) begin fails++;
      $display("FAIL beq_taken got %b want 1010011", {pcen, pcsrc, alucontrol, instr_done}); end
    tick();  // FETCH
    exp_count = exp_count + 4'd1;
    zero = 1'b0;
    tick(); tick();  // BRANCH
    tests++; if ({pcen, pcsrc} !== 3'b001) begin fails++;
      $display("FAIL beq_not_taken got %b want 001", {pcen, pcsrc}); end
    tick();
    exp_count = exp_count + 4'd1;
    tests++; if (instr_count !== exp_count) begin fails++;
      $display("FAIL beq_count got %0d want %0d", instr_count, exp_count); end
  endtask

  task automatic test_sw_j_addi();
    logic [3:0] start = exp_count;
    op = 6'b101011;
    tick();  // DECODE
    tick();  // MEMADR
    tests++; if (memwrite !== 1'b0) begin fails++;
      $display("FAIL sw_adr_memwrite got %b want 0", memwrite); end
    tick();  // MEMWR
    tests++; if ({memwrite, iord, instr_done, regwrite} !== 4'b1110) begin fails++;
      $display("FAIL sw_wr got %b want 1110", {memwrite, iord, instr_done, regwrite}); end
    tick();  // FETCH
    tests++; if (memwrite !== 1'b0) begin fails++;
      $display("FAIL sw_fetch_memwrite got %b want 0", memwrite); end
    op = 6'b000010;
    tick(); tick();  // JUMP
    tests++; if ({pcsrc, pcen, instr_done, memwrite} !== 5'b10110) begin fails++;
      $display("FAIL j_jump got %b want 10110", {pcsrc, pcen, instr_done, memwrite}); end
    tick();
    op = 6'b001000;
    tick(); tick();  // ADDIEX
    tests++; if ({alusrca, alusrcb, alucontrol, regwrite} !== 7'b1100000) begin fails++;
      $display("FAIL addi_ex got %b want 1100000", {alusrca, alusrcb, alucontrol, regwrite}); end
    tick();  // ADDIWB
    tests++; if ({regdst, regwrite, memtoreg, instr_done} !== 4'b0101) begin fails++;
      $display("FAIL addi_wb got %b want 0101", {regdst, regwrite, memtoreg, instr_done}); end
    tick();
    exp_count = start + 4'd3;
    tests++; if (instr_count !== exp_count) begin fails++;
      $display("FAIL sja_count got %0d want %0d", instr_count, exp_count); end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    tick();  // DECODE
    tests++; if ({illegal_op, instr_done} !== 2'b10) begin fails++;
      $display("FAIL bad_op_decode got %b want 10", {illegal_op, instr_done}); end
    tick();  // back to FETCH
    tests++; if ({irwrite, illegal_op, instr_count} !== {2'b10, exp_count}) begin fails++;
      $display("FAIL bad_op_fetch got %b/%0d want 10/%0d", {irwrite, illegal_op}, instr_count,
               exp_count); end
    op = 6'b000000;
    funct = 6'b000111;
    tick();  // DECODE
    tests++; if (illegal_op !== 1'b1) begin fails++;
      $display("FAIL bad_funct_decode got %b want 1", illegal_op); end
    tick();  // EXEC
    tests++; if ({alucontrol, illegal_op} !== 4'b0000) begin fails++;
      $display("FAIL bad_funct_exec got %b want 0000", {alucontrol, illegal_op}); end
    tick();  // ALUWB
    tests++; if ({regwrite, instr_done} !== 2'b11) begin fails++;
      $display("FAIL bad_funct_wb got %b want 11", {regwrite, instr_done}); end
    tick();
    exp_count = exp_count + 4'd1;
    tests++; if (instr_count !== exp_count) begin fails++;
      $display("FAIL bad_funct_count got %0d want %0d", instr_count, exp_count); end
  endtask

  task automatic test_reset_midinstr();
    op = 6'b101011;
    tick(); tick(); tick();  // MEMWR
    tests++; if (memwrite !== 1'b1) begin fails++;
      $display("FAIL mid_memwr got %b want 1", memwrite); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({memwrite, iord, pcen, irwrite, instr_count} !== 8'b0) begin fails++;
      $display("FAIL mid_reset got %b/%0d want 0000/0", {memwrite, iord, pcen, irwrite},
               instr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_count = 4'd0;
    tests++; if ({irwrite, pcen, alusrcb, instr_count} !== 8'b1101_0000) begin fails++;
      $display("FAIL mid_release got %b/%0d want 1101/0", {irwrite, pcen, alusrcb},
               instr_count); end
  endtask

  task automatic test_wrap();
    op = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick();
      exp_count = exp_count + 4'd1;
      if (i == 14) begin
        tests++; if (instr_count !== 4'd15) begin fails++;
          $display("FAIL wrap_pre got %0d want 15", instr_count); end
      end
    end
    tests++; if (instr_count !== 4'd0 || exp_count !== 4'd0) begin fails++;
      $display("FAIL wrap got %0d want 0", instr_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_j_addi();
    test_illegal();
    test_reset_midinstr();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
